// File: rtl/fsm_stim_pkg.sv
// Shared types and defaults for the step-controller input conditioning.
// Imported by the debounce cell and the step controller top.
package fsm_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2
    } step_state_t;

    localparam int SYNC_STAGES    = 2;
    localparam int DEB_CYCLES_DEF = 16;
    localparam int AUTO_DIV_DEF   = 1000;

endpackage

// File: rtl/fsm_debounce.sv
// One raw asynchronous input: flop synchronizer followed by a
// consecutive-difference debounce counter.
module fsm_debounce
    import fsm_stim_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            cnt    <= '0;
            deb    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (sync == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fsm_step_ctrl.sv
// Conditions switches/button for a downstream Moore FSM and issues
// single-cycle step strobes, manually or from the auto prescaler.
module fsm_step_ctrl
    import fsm_stim_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int AUTO_DIV   = AUTO_DIV_DEF,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sw_raw,
    input  logic             step_btn,
    input  logic             auto_en,
    output logic [1:0]       sw_in,
    output logic             ctrl_in,
    output logic [CNT_W-1:0] step_count,
    output logic             busy
);

    localparam int PW = $clog2(AUTO_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(AUTO_DIV - 1);

    logic [1:0]  deb_sw;
    logic        deb_step;
    logic        deb_auto;
    logic        deb_step_q;
    logic [PW-1:0] pre;
    logic        man_req;
    logic        auto_tick;
    logic        req;
    logic        pending;
    logic        pend_d;
    step_state_t state;
    step_state_t state_d;

    for (genvar i = 0; i < 2; i++) begin : g_sw
        fsm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (sw_raw[i]),
            .deb   (deb_sw[i])
        );
    end

    fsm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk   (clk),
        .reset (reset),
        .raw   (step_btn),
        .deb   (deb_step)
    );

    fsm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_auto (
        .clk   (clk),
        .reset (reset),
        .raw   (auto_en),
        .deb   (deb_auto)
    );

    // The button is ignored entirely while auto mode owns the strobe.
    assign man_req   = deb_step & ~deb_step_q & ~deb_auto;
    assign auto_tick = deb_auto & (pre == PRE_MAX);
    assign req       = man_req | auto_tick;

    always_comb begin
        state_d = state;
        pend_d  = pending;
        unique case (state)
            IDLE: begin
                if (req || pending) begin
                    state_d = LOAD;
                    pend_d  = 1'b0;
                end
            end
            LOAD: begin
                state_d = STEP;
                if (req) pend_d = 1'b1;
            end
            STEP: begin
                if (req || pending) begin
                    state_d = LOAD;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_step_q <= 1'b0;
            pre        <= '0;
            state      <= IDLE;
            pending    <= 1'b0;
            busy       <= 1'b0;
            ctrl_in    <= 1'b0;
            sw_in      <= 2'b00;
            step_count <= '0;
        end else begin
            deb_step_q <= deb_step;
            if (!deb_auto)          pre <= '0;
            else if (pre == PRE_MAX) pre <= '0;
            else                    pre <= pre + PW'(1);
            state   <= state_d;
            pending <= pend_d;
            busy    <= (state_d == LOAD) || (state_d == STEP);
            ctrl_in <= (state == STEP);
            // Snapshot lands one cycle ahead of the strobe it belongs to.
            if (state == LOAD) sw_in <= deb_sw;
            if ((state == STEP) && (step_count != {CNT_W{1'b1}}))
                step_count <= step_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/fsm_step_ctrl.md
Name: fsm_step_ctrl

Overview:
- Input-conditioning stage placed directly upstream of the team's table-driven Moore FSM blocks.
- Synchronizes and debounces the raw board switches and step button, and holds a clean 2-bit switch value on sw_in.
- Issues a single-cycle ctrl_in step strobe, either manually from the button or periodically in auto mode.
- Guarantees sw_in is stable for the whole cycle in which ctrl_in is high.

Parameters:
- DEB_CYCLES, 16, consecutive cycles a synchronized input must differ from its debounced value before the debounced value flips (>=1).
- AUTO_DIV, 1000, auto-mode tick period in clk cycles (>=2).
- CNT_W, 8, width of step_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- sw_raw  input  2  raw switch levels, asynchronous to clk.
- step_btn  input  1  raw step push-button, asynchronous.
- auto_en  input  1  raw auto-step enable switch, asynchronous.
- sw_in  output  2  registered switch snapshot presented to the FSM.
- ctrl_in  output  1  registered one-cycle step strobe to the FSM.
- step_count  output  CNT_W  number of strobes issued, saturating.
- busy  output  1  high while in LOAD or STEP.

Behaviour:
- Reset (reset=0, asynchronous): sw_in=0, ctrl_in=0, step_count=0, busy=0, FSM=IDLE, pending=0. Synchronizers, debounced values, debounce counters and prescaler all go to 0. Reset asserted mid-operation aborts any LOAD/STEP with no strobe.
- Synchronizer: 2 flops per raw input.
- Debounce (per bit): counter clears whenever sync==deb. Otherwise it increments. When it reaches DEB_CYCLES-1 with sync!=deb, deb<=sync and the counter clears.
- A button held through reset release produces exactly one step after debounce, because deb resets to 0.
- Manual request: rising edge of deb_step (deb_step & ~deb_step_q). Ignored while deb_auto=1.
- Auto request: the prescaler counts 0..AUTO_DIV-1 while deb_auto=1 and wraps. A tick fires in the cycle count==AUTO_DIV-1. When deb_auto=0, the prescaler is held at 0.
- Step FSM states: IDLE, LOAD, STEP.
  - IDLE: if a request or pending is set -> LOAD, and pending clears.
  - LOAD: sw_in <= deb_sw at the edge leaving LOAD -> STEP.
  - STEP: ctrl_in=1 for exactly this cycle; step_count increments (holds at 2^CNT_W-1) -> LOAD if pending, else IDLE.
- Request while in LOAD or STEP: sets pending. Multiple requests coalesce into one pending flag.
- A request arriving in the same cycle the FSM leaves STEP counts as pending.
- Latency (manual): ctrl_in is high 2+DEB_CYCLES+2 cycles after the first edge that samples the new raw button level.
- sw_in changes only at the LOAD exit edge. It is never updated while ctrl_in=1 and holds between steps.
- busy = (state==LOAD || state==STEP), registered with the state.

Decomposition:
- Package fsm_stim_pkg holds:
  - step_state_t enum {IDLE, LOAD, STEP}
  - SYNC_STAGES=2
  - default constants DEB_CYCLES_DEF and AUTO_DIV_DEF
- Sub-module fsm_debounce: 1-bit synchronizer plus debounce counter, parameter DEB_CYCLES, ports clk/reset/raw/deb.
- Instantiated 4 times: sw_raw[0], sw_raw[1], step_btn, auto_en.
- Edge detect, prescaler and step FSM live in the top.

Test Plan:
All scenarios use DEB_CYCLES=4, AUTO_DIV=8, CNT_W=3.
1. Reset: hold reset=0 for 5 cycles while toggling all inputs -> every output stays 0. After release with inputs at 0, no ctrl_in for 50 cycles.
2. Manual step:
   - Stimulus: sw_raw=2'b10 stable, then step_btn=1 held 20 cycles.
   - Required: sw_in=2'b10 one cycle before ctrl_in; ctrl_in high for 1 cycle, 8 cycles after the sampling edge; step_count=1; busy high for 2 cycles.
   - Then change sw_raw=2'b01 with no button press -> sw_in stays 2'b10.
3. Bounce: step_btn toggles 1,0,1,0 every 2 cycles, then holds 1 -> exactly one ctrl_in pulse, step_count=1.
4. Auto mode:
   - auto_en=1 stable -> ctrl_in pulses every 8 cycles, and step_count increments per pulse.
   - Button presses during auto mode -> no extra pulses.
   - auto_en=0 -> pulses stop; a subsequent manual press gives one pulse.
5. Saturation/pending: issue 10 manual steps, with one press arriving during LOAD -> the press mid-LOAD gives a back-to-back STEP via LOAD, and step_count holds at 7.
6. Reset mid-operation: assert reset while state=LOAD -> outputs go to 0 before the next clk edge, and no ctrl_in pulse follows.
